// File: rtl/freq_word_scheduler.sv
// DDS tuning-word sequencer: arbitrates rotary and sweep index requests,
// reads the frequency ROM and commits the word on an accumulator wrap.
module freq_word_scheduler #(
    parameter int ADDR_W       = 11,
    parameter int TW_W         = 32,
    parameter int ADDR_MAX     = 1800,
    parameter int SWEEP_MIN    = 800,
    parameter int SWEEP_MODE   = 5,
    parameter int SWEEP_DWELL  = 2400,
    parameter int WRAP_TIMEOUT = 4096
) (
    input  logic              Fg_clk,
    input  logic              Resetn,
    input  logic [2:0]        Mode,
    input  logic [ADDR_W-1:0] rot_address,
    input  logic              rot_chng,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TW_W-1:0]   rom_data,
    input  logic              phase_wrap,
    output logic [TW_W-1:0]   tw_out,
    output logic              tw_load,
    output logic [ADDR_W-1:0] cur_address,
    output logic              busy
);

    localparam int DW_W = $clog2(SWEEP_DWELL + 1);
    localparam int TO_W = $clog2(WRAP_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] AMAX       = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] SMIN       = ADDR_W'(SWEEP_MIN);
    localparam logic [2:0]        MODE_SW    = 3'(SWEEP_MODE);
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(SWEEP_DWELL - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(WRAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WAIT,
        COMMIT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cur_q;
    logic [TW_W-1:0]   word_q;
    logic [TW_W-1:0]   tw_out_q;
    logic              tw_load_q;
    logic              rot_pend_q;
    logic [ADDR_W-1:0] rot_idx_q;
    logic              swp_pend_q;
    logic [ADDR_W-1:0] swp_req_q;
    logic [ADDR_W-1:0] swp_idx_q;
    logic [DW_W-1:0]   dwell_q;
    logic [TO_W-1:0]   tmo_q;

    function automatic logic [ADDR_W-1:0] clamp(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        m
    );
        logic [ADDR_W-1:0] r;
        r = a;
        if (a > AMAX)
            r = AMAX;
        else if (m == 3'd4 && a < SMIN)
            r = SMIN;
        return r;
    endfunction

    // Request capture is placed after the FSM so a new request in the
    // same cycle as a grant re-arms the pending flag.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            idx_q      <= '0;
            cur_q      <= '0;
            word_q     <= '0;
            tw_out_q   <= '0;
            tw_load_q  <= 1'b0;
            rot_pend_q <= 1'b0;
            rot_idx_q  <= '0;
            swp_pend_q <= 1'b0;
            swp_req_q  <= '0;
            swp_idx_q  <= SMIN;
            dwell_q    <= '0;
            tmo_q      <= '0;
        end else begin
            tw_load_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rot_pend_q) begin
                        rot_pend_q <= 1'b0;
                        if (rot_idx_q != cur_q) begin
                            rom_addr_q <= rot_idx_q;
                            idx_q      <= rot_idx_q;
                            state_q    <= READ;
                        end
                    end else if (swp_pend_q) begin
                        swp_pend_q <= 1'b0;
                        if (swp_req_q != cur_q) begin
                            rom_addr_q <= swp_req_q;
                            idx_q      <= swp_req_q;
                            state_q    <= READ;
                        end
                    end
                end
                READ: state_q <= CAPT;
                CAPT: begin
                    word_q  <= rom_data;
                    tmo_q   <= '0;
                    state_q <= (tw_out_q == '0) ? COMMIT : WAIT;
                end
                WAIT: begin
                    if (phase_wrap) begin
                        tw_out_q  <= word_q;
                        cur_q     <= idx_q;
                        tw_load_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (tmo_q == TO_LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        tmo_q <= tmo_q + TO_W'(1);
                    end
                end
                COMMIT: begin
                    tw_out_q  <= word_q;
                    cur_q     <= idx_q;
                    tw_load_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (rot_chng) begin
                rot_pend_q <= 1'b1;
                rot_idx_q  <= clamp(rot_address, Mode);
            end

            if (Mode == MODE_SW) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_q    <= '0;
                    swp_pend_q <= 1'b1;
                    swp_req_q  <= clamp(swp_idx_q, Mode);
                    swp_idx_q  <= (swp_idx_q >= AMAX) ? SMIN
                                                      : swp_idx_q + ADDR_W'(1);
                end else begin
                    dwell_q <= dwell_q + DW_W'(1);
                end
            end else begin
                dwell_q    <= '0;
                swp_pend_q <= 1'b0;
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign tw_out      = tw_out_q;
    assign tw_load     = tw_load_q;
    assign cur_address = cur_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_freq_word_scheduler.sv
// Directed bench for freq_word_scheduler with a registered ROM model
// and a tw_load monitor that logs committed indices.
module tb_freq_word_scheduler;

    localparam int AW = 11;
    localparam int TW = 32;

    logic          Fg_clk = 1'b0;
    logic          Resetn = 1'b0;
    logic [2:0]    Mode = 3'd0;
    logic [AW-1:0] rot_address = '0;
    logic          rot_chng = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [TW-1:0] rom_data;
    logic          phase_wrap = 1'b0;
    logic [TW-1:0] tw_out;
    logic          tw_load;
    logic [AW-1:0] cur_address;
    logic          busy;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_loads = 0;
    int load_idx[$];

    freq_word_scheduler #(
        .SWEEP_DWELL(16)
    ) dut (
        .Fg_clk     (Fg_clk),
        .Resetn     (Resetn),
        .Mode       (Mode),
        .rot_address(rot_address),
        .rot_chng   (rot_chng),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .phase_wrap (phase_wrap),
        .tw_out     (tw_out),
        .tw_load    (tw_load),
        .cur_address(cur_address),
        .busy       (busy)
    );

    always #5 Fg_clk = ~Fg_clk;

    always @(posedge Fg_clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_f(input logic [AW-1:0] a);
        if (a == 11'd1000)
            return 32'h00A3_D70A;
        return {5'd0, a, 16'h1234};
    endfunction

    always @(posedge Fg_clk) rom_data <= rom_f(rom_addr);

    always @(negedge Fg_clk) begin
        if (tw_load === 1'b1) begin
            n_loads++;
            load_idx.push_back(int'(cur_address));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_rot(input logic [AW-1:0] a, output int c0);
        rot_address = a;
        rot_chng    = 1'b1;
        c0          = cyc;
        @(negedge Fg_clk);
        rot_chng = 1'b0;
    endtask

    task automatic wait_load(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Fg_clk);
            if (tw_load === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int c0, at, early, base, bcnt, n, s, e;

        repeat (3) @(negedge Fg_clk);
        chk("rst_tw_out", tw_out, 32'h0);
        chk("rst_tw_load", {31'd0, tw_load}, 32'd0);
        chk("rst_cur", {21'd0, cur_address}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
        Resetn = 1'b1;
        repeat (2) @(negedge Fg_clk);

        // stopped DDS: commit without waiting for a wrap
        pulse_rot(11'd1000, c0);
        wait_load(20, at);
        chk("t1_latency", at - c0, 32'd5);
        chk("t1_tw_out", tw_out, 32'h00A3_D70A);
        chk("t1_cur", {21'd0, cur_address}, 32'd1000);
        @(negedge Fg_clk);
        chk("t1_pulse_width", {31'd0, tw_load}, 32'd0);

        // wrap 40 cycles after CAPT; an early wrap in IDLE is ignored
        pulse_rot(11'd1200, c0);
        phase_wrap = 1'b1;
        @(negedge Fg_clk);
        phase_wrap = 1'b0;
        early = 0;
        while (cyc < c0 + 43) begin
            @(negedge Fg_clk);
            if (tw_load === 1'b1) early++;
        end
        chk("t2_busy_wait", {31'd0, busy}, 32'd1);
        phase_wrap = 1'b1;
        @(negedge Fg_clk);
        phase_wrap = 1'b0;
        chk("t2_early_load", early, 32'd0);
        chk("t2_load", {31'd0, tw_load}, 32'd1);
        chk("t2_tw_out", tw_out, rom_f(11'd1200));
        chk("t2_cur", {21'd0, cur_address}, 32'd1200);

        // forced commit after timeout
        pulse_rot(11'd1250, c0);
        wait_load(4300, at);
        chk("t3_latency", at - c0, 32'd4101);
        chk("t3_cur", {21'd0, cur_address}, 32'd1250);

        // coalescing of requests arriving while busy
        pulse_rot(11'd1050, c0);
        pulse_rot(11'd1100, c0);
        pulse_rot(11'd1150, c0);
        pulse_rot(11'd1300, c0);
        base = load_idx.size();
        phase_wrap = 1'b1;
        repeat (20) @(negedge Fg_clk);
        phase_wrap = 1'b0;
        repeat (2) @(negedge Fg_clk);
        n = load_idx.size() - base;
        chk("t4_commits", n, 32'd2);
        if (n >= 2) begin
            chk("t4_first", load_idx[base], 32'd1050);
            chk("t4_second", load_idx[base+1], 32'd1300);
        end
        chk("t4_cur", {21'd0, cur_address}, 32'd1300);

        // clamps and duplicate-request drop
        Mode = 3'd4;
        pulse_rot(11'd500, c0);
        phase_wrap = 1'b1;
        repeat (12) @(negedge Fg_clk);
        phase_wrap = 1'b0;
        Mode = 3'd0;
        chk("t5_mode4_clamp", {21'd0, cur_address}, 32'd800);
        pulse_rot(11'd2000, c0);
        phase_wrap = 1'b1;
        repeat (12) @(negedge Fg_clk);
        phase_wrap = 1'b0;
        chk("t5_max_clamp", {21'd0, cur_address}, 32'd1800);
        chk("t5_max_word", tw_out, rom_f(11'd1800));
        base = n_loads;
        bcnt = 0;
        pulse_rot(11'd1800, c0);
        repeat (10) begin
            @(negedge Fg_clk);
            if (busy === 1'b1) bcnt++;
        end
        chk("t5_dup_busy", bcnt, 32'd0);
        chk("t5_dup_loads", n_loads - base, 32'd0);

        // reset in the middle of a WAIT
        pulse_rot(11'd900, c0);
        repeat (8) @(negedge Fg_clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        base = n_loads;
        Resetn = 1'b0;
        #1;
        chk("rst_mid_tw_out", tw_out, 32'h0);
        chk("rst_mid_cur", {21'd0, cur_address}, 32'd0);
        chk("rst_mid_busy0", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge Fg_clk);
        Resetn = 1'b1;
        repeat (3) @(negedge Fg_clk);
        chk("rst_mid_loads", n_loads - base, 32'd0);

        // sweep with a rotary request on the first tick
        phase_wrap = 1'b1;
        base = load_idx.size();
        Mode = 3'd5;
        s = cyc;
        repeat (15) @(negedge Fg_clk);
        pulse_rot(11'd1500, c0);
        chk("t6_tick_align", c0 - s, 32'd15);
        for (int i = 0; i < 20000; i++) begin
            if (load_idx.size() - base >= 1003) break;
            @(negedge Fg_clk);
        end
        Mode = 3'd0;
        phase_wrap = 1'b0;
        repeat (4) @(negedge Fg_clk);
        n = load_idx.size() - base;
        chk("t6_commits", n, 32'd1003);
        for (int k = 0; k < 1003; k++) begin
            if (k < n) begin
                if (k == 0)
                    e = 1500;
                else if (k == 1002)
                    e = 800;
                else
                    e = 800 + k - 1;
                chk($sformatf("t6_idx%0d", k), load_idx[base+k], e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
